irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- 6502 interrupt aggregator between the peripheral IRQ lines (VIA1, VIA2, UART and its four channel IRQs) and the CPU IRQB pin.
- Replaces the plain AND of IRQ lines with these stages: synchronisation, per-source edge/level mode, pending latch, mask, and a priority vector register.
- Memory-mapped inside the bifrost chip-select window, so the CPU can identify and acknowledge sources.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each source input (min 2)
MASK_RESET, 8'h00, MASK register value after reset
MODE_RESET, 8'h00, MODE register value after reset (1 = edge, 0 = level)

Ports:
clock  input  1  system clock (8 MHz)
reset  input  1  asynchronous reset, active-low
phi2  input  1  CPU bus clock, synchronous to clock (divided from it)
cs_n  input  1  register select, active-low
rw  input  1  CPU R/W (1 = read)
addr  input  3  register index
data_in  input  8  CPU write data
data_out  output  8  register read data
data_oe  output  1  high when data_out must drive the bus
src_n  input  7  peripheral IRQs, active-low: [6] via1, [5] via2, [4] uart, [3] uart_txa, [2] uart_rxa, [1] uart_txb, [0] uart_rxb
irq_n  output  1  to CPU IRQB, active-low, registered

Behaviour:
- Bit map for all 8-bit registers: source i sits at bit i+1. Bit 0 is reserved: it always reads 0 and writes to it are ignored.
- Synchroniser: SYNC_STAGES flops per src_n, reset to 1 (inactive). active[i] = ~synced src_n[i].
- Pending register PEND[7:1]:
  - Level mode: PEND[i] <= active[i] every clock. Write-1-to-clear has no lasting effect.
  - Edge mode: PEND[i] <= 1 on the clock where active[i] rises, i.e. the previous synced value was inactive.
  - Edge mode clear: a W1C write to PENDING clears the bit. Set wins if a rise and a clear occur in the same cycle.
  - Changing a bit's MODE does not alter PEND immediately. Level bits follow active from the next clock.
- irq_n <= ~|(PEND & MASK) every clock.
- Latency: src_n low, sampled at edge k, gives irq_n low after edge k+SYNC_STAGES+1 (k+3 at default).
- Masking a pending bit raises irq_n on the next clock. PEND is retained.
- Bus write:
  - Write strobe = phi2 high on the previous clock AND phi2 low now (falling edge) AND ~cs_n AND ~rw.
  - At most one register update per bus cycle.
- Register map (addr):
  - 0 STATUS: read returns {active, 0}. Write ignored.
  - 1 PENDING: read returns {PEND, 0}. Write is W1C on edge-mode bits.
  - 2 MASK: read/write.
  - 3 MODE: read/write.
  - 4 VECTOR: read-only. Returns the index 1..7 of the highest set bit of PEND & MASK (bit 7 highest priority), or 8'hFF if none.
  - 5..7: read 8'h00, writes ignored.
- Reads: data_oe = ~cs_n & rw & phi2. data_out is combinational from the current registers and is 8'h00 when data_oe = 0.
- Reset (asynchronous, any time, including mid-write):
  - PEND = 0, MASK = MASK_RESET, MODE = MODE_RESET.
  - Synchronisers = all 1, irq_n = 1, phi2 history = 0.
  - No spurious edge is detected on release: the first rise needs a synced transition from inactive to active.
- Source already low at reset release:
  - Level mode: pending after SYNC_STAGES+1 clocks.
  - Edge mode: also pending, because the synchronisers start inactive. This is intended, so no interrupt is lost across reset.

Test Plan:
- After reset, read STATUS/PENDING/MASK/MODE/VECTOR -> 00/00/00/00/FF; irq_n = 1.
- MASK = 8'h20, src_n[4] (uart) driven low -> irq_n low exactly 3 clocks later; VECTOR = 8'h05; src_n[4] high -> irq_n high 3 clocks later.
- MODE = 8'h80, MASK = 8'h80, 1-clock-wide-at-sync low pulse on src_n[6] -> PEND = 8'h80 and stays set; write PENDING = 8'h80 -> PEND = 00 and irq_n = 1 on the following clock.
- Edge rise on via1 coincident with a W1C of bit 7 -> PEND[7] remains 1.
- src_n[6] and src_n[0] both low, MASK = 8'hFF -> VECTOR = 8'h07; MASK = 8'h02 -> VECTOR = 8'h01; MASK = 8'h00 -> VECTOR = 8'hFF and irq_n = 1.
- Assert reset during a write strobe to MASK, with a source active -> registers at reset values, irq_n = 1 immediately; bus read with cs_n high -> data_oe = 0, data_out = 00.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// CPU bus seen by the interrupt aggregator: phi2-qualified register access.
interface irq_ctrl_if;
  logic       phi2;
  logic       cs_n;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output phi2, cs_n, rw, addr, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  phi2, cs_n, rw, addr, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/irq_ctrl.sv
// 6502 interrupt aggregator: synchronises peripheral IRQ lines, latches them per edge/level
// mode, masks them and drives a registered IRQB plus a priority vector register.
module irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  MASK_RESET  = 8'h00,
  parameter logic [7:0]  MODE_RESET  = 8'h00
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  irq_ctrl_if.slave    bus,
  input  logic [6:0]   i_src_n,
  output logic         o_irq_n
);

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrPending = 3'd1;
  localparam logic [2:0] AddrMask    = 3'd2;
  localparam logic [2:0] AddrMode    = 3'd3;
  localparam logic [2:0] AddrVector  = 3'd4;

  logic [SYNC_STAGES-1:0][6:0] r_sync;
  logic [6:0] r_prev_active;
  logic [6:0] r_pend;
  logic [7:0] r_mask;
  logic [7:0] r_mode;
  logic       r_phi2;
  logic       r_irq_n;

  logic [6:0] w_active;
  logic [6:0] w_rise;
  logic [6:0] w_clr;
  logic [6:0] w_pend_d;
  logic [6:0] w_masked;
  logic       w_wr;
  logic [7:0] w_vector;
  logic [7:0] w_wdata;

  assign w_active = ~r_sync[SYNC_STAGES-1];
  assign w_rise   = w_active & ~r_prev_active;
  assign w_masked = r_pend & r_mask[7:1];
  assign w_wdata  = bus.data_in & 8'hFE;

  // One strobe per bus cycle: only on the phi2 falling edge.
  assign w_wr  = r_phi2 & ~bus.phi2 & ~bus.cs_n & ~bus.rw;
  assign w_clr = (w_wr && bus.addr == AddrPending) ? (bus.data_in[7:1] & r_mode[7:1]) : 7'h00;

  // Level bits mirror the input; edge bits latch rises and a rise beats a same-cycle clear.
  assign w_pend_d = (w_active & ~r_mode[7:1]) |
                    (r_mode[7:1] & (w_rise | (r_pend & ~w_clr)));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync        <= '1;
      r_prev_active <= '0;
      r_pend        <= '0;
      r_mask        <= MASK_RESET & 8'hFE;
      r_mode        <= MODE_RESET & 8'hFE;
      r_phi2        <= 1'b0;
      r_irq_n       <= 1'b1;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], i_src_n};
      r_prev_active <= w_active;
      r_pend        <= w_pend_d;
      r_phi2        <= bus.phi2;
      r_irq_n       <= ~|w_masked;
      if (w_wr && bus.addr == AddrMask) begin
        r_mask <= w_wdata;
      end
      if (w_wr && bus.addr == AddrMode) begin
        r_mode <= w_wdata;
      end
    end
  end

  // Ascending scan so the highest set source wins.
  always_comb begin
    w_vector = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      if (w_masked[i]) begin
        w_vector = 8'(i + 1);
      end
    end
  end

  assign bus.data_oe = ~bus.cs_n & bus.rw & bus.phi2;

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.data_oe) begin
      case (bus.addr)
        AddrStatus:  bus.data_out = {w_active, 1'b0};
        AddrPending: bus.data_out = {r_pend, 1'b0};
        AddrMask:    bus.data_out = r_mask;
        AddrMode:    bus.data_out = r_mode;
        AddrVector:  bus.data_out = w_vector;
        default:     bus.data_out = 8'h00;
      endcase
    end
  end

  assign o_irq_n = r_irq_n;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: timeline model of the interrupt rules plus directed vectors.
module tb_irq_ctrl;
  localparam int S = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] src_n = 7'h7F;
  logic       irq_n;

  irq_ctrl_if bus_if ();

  irq_ctrl #(
    .SYNC_STAGES(S),
    .MASK_RESET (8'h00),
    .MODE_RESET (8'h00)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus_if),
    .i_src_n  (src_n),
    .o_irq_n  (irq_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs logged per clock edge; a source is seen active S-1 edges after sampling.
  int         cyc = 0;
  int         rel = 1;
  logic [6:0] src_log [4096];
  logic       phi_log [4096];
  logic [6:0] m_pend   = '0;
  logic [6:0] m_mask   = '0;
  logic [6:0] m_mode   = '0;
  logic [6:0] m_active = '0;
  logic       m_irq    = 1'b1;

  function automatic logic [6:0] act_at(input int n);
    if (n - S + 1 < rel) return 7'h00;
    return ~src_log[n - S + 1];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend   = '0;
        m_mask   = '0;
        m_mode   = '0;
        m_active = '0;
        m_irq    = 1'b1;
        rel      = cyc + 1;
      end else begin
        logic [6:0] a1, a2, clr, nxt;
        logic       stb;
        cyc++;
        if (cyc >= 4096) begin
          $display("FAIL model_log: got %0d expected below 4096", cyc);
          $fatal(1, "model log overflow");
        end
        src_log[cyc] = src_n;
        phi_log[cyc] = bus_if.phi2;
        a1  = act_at(cyc - 1);
        a2  = act_at(cyc - 2);
        stb = (cyc - 1 >= rel) && phi_log[cyc - 1] && !bus_if.phi2 && !bus_if.cs_n && !bus_if.rw;
        clr = (stb && bus_if.addr == 3'd1) ? bus_if.data_in[7:1] : 7'h00;
        m_irq = ((m_pend & m_mask) == 7'h00);
        for (int i = 0; i < 7; i++) begin
          if (m_mode[i]) nxt[i] = (a1[i] && !a2[i]) || (m_pend[i] && !clr[i]);
          else           nxt[i] = a1[i];
        end
        m_pend = nxt;
        if (stb && bus_if.addr == 3'd2) m_mask = bus_if.data_in[7:1];
        if (stb && bus_if.addr == 3'd3) m_mode = bus_if.data_in[7:1];
        m_active = act_at(cyc);
      end
    end
  end

  function automatic logic [7:0] exp_data();
    logic [6:0] hit;
    logic [7:0] vec;
    if (!(!bus_if.cs_n && bus_if.rw && bus_if.phi2)) return 8'h00;
    hit = m_pend & m_mask;
    vec = 8'hFF;
    for (int i = 6; i >= 0; i--) begin
      if (hit[i] && vec == 8'hFF) vec = 8'(i + 1);
    end
    case (bus_if.addr)
      3'd0:    return {m_active, 1'b0};
      3'd1:    return {m_pend, 1'b0};
      3'd2:    return {m_mask, 1'b0};
      3'd3:    return {m_mode, 1'b0};
      3'd4:    return vec;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("model_irq_n", irq_n, m_irq);
      check("model_data_oe", bus_if.data_oe, !bus_if.cs_n && bus_if.rw && bus_if.phi2);
      check("model_data_out", bus_if.data_out, exp_data());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.phi2 = 1'b1; bus_if.cs_n = 1'b0; bus_if.rw = 1'b0;
    bus_if.addr = a;    bus_if.data_in = d;
    @(negedge clk);
    bus_if.phi2 = 1'b0;
    @(negedge clk);
    bus_if.cs_n = 1'b1; bus_if.rw = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus_if.phi2 = 1'b1; bus_if.cs_n = 1'b0; bus_if.rw = 1'b1; bus_if.addr = a;
    tick();
    check(name, bus_if.data_out, exp);
    check({name, "_oe"}, bus_if.data_oe, 8'h01);
    @(negedge clk);
    bus_if.phi2 = 1'b0; bus_if.cs_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.phi2 = 1'b0; bus_if.cs_n = 1'b1; bus_if.rw = 1'b1;
    bus_if.addr = 3'd0; bus_if.data_in = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    bus_read(3'd0, 8'h00, "rst_status");
    bus_read(3'd1, 8'h00, "rst_pending");
    bus_read(3'd2, 8'h00, "rst_mask");
    bus_read(3'd3, 8'h00, "rst_mode");
    bus_read(3'd4, 8'hFF, "rst_vector");
    check("rst_irq_n", irq_n, 8'h01);

    // Level source latency, both directions
    bus_write(3'd2, 8'h20);
    src_n[4] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("lvl_irq_still_high", irq_n, 8'h01);
    end
    tick();
    check("lvl_irq_low_k3", irq_n, 8'h00);
    bus_read(3'd4, 8'h05, "lvl_vector");
    bus_read(3'd0, 8'h20, "lvl_status");
    bus_read(3'd1, 8'h20, "lvl_pending");
    src_n[4] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("lvl_irq_still_low", irq_n, 8'h00);
    end
    tick();
    check("lvl_irq_high_k3", irq_n, 8'h01);

    // Edge mode: short pulse latches, W1C clears
    bus_write(3'd3, 8'h80);
    bus_write(3'd2, 8'h80);
    @(negedge clk); src_n[6] = 1'b0;
    @(negedge clk); src_n[6] = 1'b1;
    repeat (4) tick();
    bus_read(3'd1, 8'h80, "edge_pend_set");
    check("edge_irq_low", irq_n, 8'h00);
    repeat (5) tick();
    bus_read(3'd1, 8'h80, "edge_pend_held");
    bus_write(3'd1, 8'h80);
    tick();
    check("edge_w1c_irq_high", irq_n, 8'h01);
    bus_read(3'd1, 8'h00, "edge_w1c_pend");

    // Rise coincident with W1C: set wins
    @(negedge clk); src_n[6] = 1'b0;
    bus_write(3'd1, 8'h80);
    bus_read(3'd1, 8'h80, "coincide_pend");
    src_n[6] = 1'b1;
    repeat (3) tick();
    bus_write(3'd1, 8'h80);
    bus_read(3'd1, 8'h00, "coincide_cleared");

    // Priority vector
    bus_write(3'd3, 8'h00);
    @(negedge clk); src_n[6] = 1'b0; src_n[0] = 1'b0;
    bus_write(3'd2, 8'hFF);
    repeat (3) tick();
    bus_read(3'd4, 8'h07, "vec_all");
    bus_write(3'd2, 8'h02);
    bus_read(3'd4, 8'h01, "vec_low");
    bus_write(3'd2, 8'h00);
    tick();
    check("vec_none_irq", irq_n, 8'h01);
    bus_read(3'd4, 8'hFF, "vec_none");

    // Reset in the middle of a MASK write with sources active
    bus_write(3'd2, 8'hFF);
    repeat (2) tick();
    check("pre_reset_irq", irq_n, 8'h00);
    @(negedge clk);
    bus_if.phi2 = 1'b1; bus_if.cs_n = 1'b0; bus_if.rw = 1'b0;
    bus_if.addr = 3'd2; bus_if.data_in = 8'h55;
    @(negedge clk);
    bus_if.phi2 = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_irq_immediate", irq_n, 8'h01);
    bus_if.cs_n = 1'b1; bus_if.rw = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(3'd2, 8'h00, "post_reset_mask");
    bus_read(3'd3, 8'h00, "post_reset_mode");
    @(negedge clk);
    bus_if.phi2 = 1'b1; bus_if.rw = 1'b1; bus_if.cs_n = 1'b1; bus_if.addr = 3'd4;
    tick();
    check("nocs_data_oe", bus_if.data_oe, 8'h00);
    check("nocs_data_out", bus_if.data_out, 8'h00);
    @(negedge clk);
    bus_if.phi2 = 1'b0;
    src_n = 7'h7F;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
